// File: rtl/ppu_cfg_pkg.sv
// Shared types and constants for the PPU configuration slave.
// Holds the FSM state enum, the output pattern mode enum and default sizes.
package ppu_cfg_pkg;

  localparam int NBYTES_DEFAULT = 10;
  localparam int DW_DEFAULT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MODE_PASS       = 3'd0,
    MODE_INV        = 3'd1,
    MODE_ROTL       = 3'd2,
    MODE_MIRROR_XOR = 3'd3,
    MODE_FRAME_ADD  = 3'd4,
    MODE_MASK5      = 3'd5,
    MODE_MASK6      = 3'd6,
    MODE_MASK7      = 3'd7
  } mode_e;

endpackage

// File: rtl/ppu_cfg_slave_regfile.sv
// NBYTES x DW configuration storage: one write port, two combinational
// read ports (the pattern pointer and its mirror NBYTES-1-ptr).
module ppu_cfg_regfile #(
  parameter int NBYTES = 10,
  parameter int DW     = 8,
  parameter int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NBYTES];

  // Storage write; reset clears every byte so a fresh block never shows stale data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NBYTES; i++) r_mem[i] <= '0;
    end else if (i_we && (int'(i_waddr) < NBYTES)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range addresses read as zero rather than indexing past the array.
  assign o_rdata_a = (int'(i_raddr_a) < NBYTES) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (int'(i_raddr_b) < NBYTES) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/ppu_cfg_slave.sv
// PPU configuration slave: loads an NBYTES configuration burst from an
// initiator, then streams pattern bytes derived from it to a consumer.
// Optional feature macro: PPU_CFG_CHECKSUM_EN (adds a trailing XOR checksum
// byte to each burst; a wrong checksum aborts to IDLE with cfg_err set).
//
// Handshakes: in_stb is held with in_data until in_ack; in_ack is a
// one-cycle pulse registered from the accepting edge, so a byte sampled at
// edge N is acknowledged during cycle N+1 and the next byte can be taken at
// edge N+2 at the earliest. out_stb/out_data form a valid/ready pair with
// out_ack: a transfer happens on any edge where both are high, and the
// following byte appears registered in the next cycle.
module ppu_cfg_slave
  import ppu_cfg_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  parameter int DW     = DW_DEFAULT
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic          sync,
  input  logic [2:0]    mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_stb,
  output logic          in_ack,
  output logic [DW-1:0] out_data,
  output logic          out_stb,
  input  logic          out_ack,
  output logic          cfg_valid,
  output logic          cfg_err,
  output logic [1:0]    o_dbg_state
);

  localparam int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IW = $clog2(NBYTES + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(NBYTES - 1);

  state_e        r_state;
  logic          r_in_ack;
  logic          r_out_stb;
  logic [DW-1:0] r_out_data;
  logic          r_cfg_valid;
  logic          r_cfg_err;
  logic [IW-1:0] r_index;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_frame;

  logic          w_accept;
  logic          w_we;
  logic          w_load_done;
  logic          w_csum_bad;
  logic [AW-1:0] w_waddr;
  logic          w_hs;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_ptr_mir;
  logic [DW-1:0] w_frame_nxt;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic [DW-1:0] w_byte_a;
  logic [DW-1:0] w_byte_b;
  logic [2:0]    w_rot_amt;
  logic [DW-1:0] w_pattern;
  mode_e         w_mode;

  // A byte is taken only in LOAD with sync still high and no ack pending.
  assign w_accept = (r_state == ST_LOAD) && sync && in_stb && !r_in_ack;
  assign w_waddr  = AW'(r_index);

`ifdef PPU_CFG_CHECKSUM_EN
  localparam logic [IW-1:0] CSUM_IDX = IW'(NBYTES);
  logic [DW-1:0] r_csum;

  // Running XOR of payload bytes; restarts whenever the block leaves LOAD.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)               r_csum <= '0;
    else if (r_state != ST_LOAD)  r_csum <= '0;
    else if (w_we)                r_csum <= r_csum ^ in_data;
  end

  assign w_we        = w_accept && (r_index != CSUM_IDX);
  assign w_load_done = w_accept && (r_index == CSUM_IDX) && (in_data == r_csum);
  assign w_csum_bad  = w_accept && (r_index == CSUM_IDX) && (in_data != r_csum);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  assign w_we        = w_accept;
  assign w_load_done = w_accept && (r_index == LAST_IDX);
  assign w_csum_bad  = 1'b0;
`endif

  // Pointer/frame that the next registered out_data will be computed for.
  assign w_hs        = (r_state == ST_ACTIVE) && r_out_stb && out_ack;
  assign w_ptr_nxt   = !w_hs ? r_ptr : ((r_ptr == LAST_PTR) ? '0 : r_ptr + AW'(1));
  assign w_frame_nxt = (w_hs && (r_ptr == LAST_PTR)) ? r_frame + DW'(1) : r_frame;
  assign w_ptr_mir   = LAST_PTR - w_ptr_nxt;

  ppu_cfg_regfile #(
    .NBYTES (NBYTES),
    .DW     (DW),
    .AW     (AW)
  ) u_regfile (
    .i_clk     (clk_pix),
    .i_rst_n   (rst_pix_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (in_data),
    .i_raddr_a (w_ptr_nxt),
    .i_raddr_b (w_ptr_mir),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // The first pattern byte is built on the same edge the final payload byte
  // is written, so a read that hits the byte being written takes it directly.
  assign w_byte_a = (w_we && (w_waddr == w_ptr_nxt)) ? in_data : w_rd_a;
  assign w_byte_b = (w_we && (w_waddr == w_ptr_mir)) ? in_data : w_rd_b;
  assign w_mode   = mode_e'(mode);

  // Pattern function: selected transform of cfg[ptr] for the upcoming output.
  always_comb begin
    w_pattern = '0;
    w_rot_amt = 3'(w_ptr_nxt);
    case (w_mode)
      MODE_PASS:       w_pattern = w_byte_a;
      MODE_INV:        w_pattern = ~w_byte_a;
      MODE_ROTL:       w_pattern = (w_byte_a << w_rot_amt) | (w_byte_a >> (DW - int'(w_rot_amt)));
      MODE_MIRROR_XOR: w_pattern = w_byte_a ^ w_byte_b;
      MODE_FRAME_ADD:  w_pattern = w_byte_a + w_frame_nxt;
      default:         w_pattern = {w_byte_a[DW-1:2], 2'b00};
    endcase
  end

  // Control FSM: IDLE waits for sync, LOAD collects the burst, ACTIVE streams.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state     <= ST_IDLE;
      r_in_ack    <= 1'b0;
      r_out_stb   <= 1'b0;
      r_out_data  <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_index     <= '0;
      r_ptr       <= '0;
      r_frame     <= '0;
    end else begin
      r_in_ack <= w_accept;
      case (r_state)
        ST_IDLE: begin
          if (sync) begin
            r_state     <= ST_LOAD;
            r_index     <= '0;
            r_ptr       <= '0;
            r_frame     <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!sync) begin
            r_state     <= ST_IDLE;
            r_cfg_err   <= 1'b1;
            r_cfg_valid <= 1'b0;
          end else if (w_accept) begin
            r_index <= r_index + IW'(1);
            if (w_load_done) begin
              r_state     <= ST_ACTIVE;
              r_cfg_valid <= 1'b1;
              r_out_stb   <= 1'b1;
              r_out_data  <= w_pattern;
            end else if (w_csum_bad) begin
              r_state   <= ST_IDLE;
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (sync) begin
            r_state     <= ST_LOAD;
            r_out_stb   <= 1'b0;
            r_out_data  <= '0;
            r_cfg_valid <= 1'b0;
            r_index     <= '0;
            r_ptr       <= '0;
            r_frame     <= '0;
          end else begin
            r_ptr      <= w_ptr_nxt;
            r_frame    <= w_frame_nxt;
            r_out_data <= w_pattern;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ack      = r_in_ack;
  assign out_stb     = r_out_stb;
  assign out_data    = r_out_data;
  assign cfg_valid   = r_cfg_valid;
  assign cfg_err     = r_cfg_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ppu_cfg_slave.sv
// Bench for ppu_cfg_slave (default NBYTES=10, DW=8). Directed steps plus
// randomized bursts/modes/acks checked against a behavioural pattern model.
module tb_ppu_cfg_slave;

  localparam int NB = 10;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_ACTIVE = 2'd2;
  localparam int ACK_ZERO = 0, ACK_ONE = 1, ACK_RND = 2;
`ifdef PPU_CFG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
  bit csum_corrupt = 1'b0;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk_pix = 1'b0;
  logic       rst_pix_n = 1'b0;
  logic       sync = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_stb = 1'b0;
  logic       in_ack;
  logic [7:0] out_data;
  logic       out_stb;
  logic       out_ack = 1'b1;
  logic       cfg_valid;
  logic       cfg_err;
  logic [1:0] dbg_state;

  int         n_vec = 0;
  int         n_fail = 0;
  int         m_cfg [NB];
  int         m_ptr = 0;
  int         m_frame = 0;
  logic [7:0] exp_q [$];
  logic [7:0] obs_log [64];
  int         log_n = 0;
  logic [7:0] burst [NB];
  logic [7:0] spec_burst [NB] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};
  logic [7:0] inv_exp [5] = '{8'hD5, 8'h84, 8'hA8, 8'h00, 8'hFF};
  logic [7:0] frame_exp [4] = '{8'd43, 8'd124, 8'd88, 8'd0};

  ppu_cfg_slave dut (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .sync        (sync),
    .mode        (mode),
    .in_data     (in_data),
    .in_stb      (in_stb),
    .in_ack      (in_ack),
    .out_data    (out_data),
    .out_stb     (out_stb),
    .out_ack     (out_ack),
    .cfg_valid   (cfg_valid),
    .cfg_err     (cfg_err),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk_pix = ~clk_pix;

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern from the rules: transform of cfg[ptr] for a mode.
  function automatic logic [7:0] out_model(input int md);
    int c, o, p;
    p = m_ptr;
    c = m_cfg[p];
    case (md)
      0:       o = c;
      1:       o = 255 - c;
      2:       o = ((c << (p % 8)) | (c >> (8 - (p % 8)))) % 256;
      3:       o = c ^ m_cfg[NB - 1 - p];
      4:       o = (c + m_frame) % 256;
      default: o = c - (c % 4);
    endcase
    return 8'(o);
  endfunction

  task automatic model_advance();
    if (m_ptr == NB - 1) begin
      m_ptr = 0;
      m_frame = (m_frame + 1) % 256;
    end else begin
      m_ptr++;
    end
  endtask

  // Present one byte and wait (bounded) for its ack pulse.
  task automatic send_byte(input logic [7:0] b, output bit acked);
    in_data = b;
    in_stb = 1'b1;
    acked = 1'b0;
    for (int k = 0; k < 8 && !acked; k++) begin
      step();
      if (in_ack === 1'b1) acked = 1'b1;
    end
    in_stb = 1'b0;
  endtask

  // Full burst from `burst`; sync dropped right after the final ack.
  task automatic load_burst();
    bit acked;
    bit ok;
    logic [7:0] x;
    sync = 1'b1;
    in_stb = 1'b0;
    step();
    chk("load_enter_state", dbg_state, S_LOAD);
    chk("load_enter_err", cfg_err, 0);
    chk("load_enter_valid", cfg_valid, 0);
    chk("load_enter_ostb", out_stb, 0);
    x = 8'd0;
    for (int i = 0; i < NB; i++) begin
      send_byte(burst[i], acked);
      chk("ack_seen", acked, 1);
      m_cfg[i] = burst[i];
      x = x ^ burst[i];
      if (i < NB - 1 || CSUM) begin
        chk("load_valid_low", cfg_valid, 0);
        step();
        chk("ack_one_cycle", in_ack, 0);
      end
    end
    ok = 1'b1;
`ifdef PPU_CFG_CHECKSUM_EN
    send_byte(x ^ {7'd0, csum_corrupt}, acked);
    chk("csum_ack_seen", acked, 1);
    ok = !csum_corrupt;
`endif
    sync = 1'b0;
    m_ptr = 0;
    m_frame = 0;
    log_n = 0;
    if (ok) begin
      chk("done_valid", cfg_valid, 1);
      chk("done_err", cfg_err, 0);
      chk("done_ostb", out_stb, 1);
      chk("done_state", dbg_state, S_ACTIVE);
      chk("first_out", out_data, out_model(int'(mode)));
      obs_log[log_n] = out_data;
      log_n++;
    end else begin
      chk("bad_valid", cfg_valid, 0);
      chk("bad_err", cfg_err, 1);
      chk("bad_ostb", out_stb, 0);
      chk("bad_state", dbg_state, S_IDLE);
    end
  endtask

  // ACTIVE traffic with model check each cycle.
  task automatic run_active(input int ncyc, input int ack_sel, input bit rnd_mode, input bit stb_noise);
    logic ack_v;
    for (int c = 0; c < ncyc; c++) begin
      ack_v = (ack_sel == ACK_RND) ? 1'($urandom_range(0, 1)) : (ack_sel == ACK_ONE);
      if (rnd_mode) mode = 3'($urandom_range(0, 7));
      in_stb = stb_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data = 8'($urandom);
      out_ack = ack_v;
      step();
      if (ack_v) model_advance();
      exp_q.push_back(out_model(int'(mode)));
      chk("out_data", out_data, exp_q.pop_front());
      chk("out_stb_active", out_stb, 1);
      chk("in_ack_active", in_ack, 0);
      chk("valid_active", cfg_valid, 1);
      if (log_n < 64) begin
        obs_log[log_n] = out_data;
        log_n++;
      end
    end
    in_stb = 1'b0;
    out_ack = 1'b1;
  endtask

  task automatic random_burst();
    for (int i = 0; i < NB; i++) burst[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    bit acked;
    logic [7:0] hold_v;
    for (int i = 0; i < NB; i++) m_cfg[i] = 0;

    // reset state
    step();
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_stb", out_stb, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_state", dbg_state, S_IDLE);
    rst_pix_n = 1'b1;
    in_stb = 1'b1;
    step();
    step();
    chk("idle_stb_ignored", in_ack, 0);
    chk("idle_stays", dbg_state, S_IDLE);
    in_stb = 1'b0;

    // reference burst, mode 0
    for (int i = 0; i < NB; i++) burst[i] = spec_burst[i];
    mode = 3'd0;
    load_burst();
    run_active(12, ACK_ONE, 1'b0, 1'b0);
    for (int i = 0; i <= NB; i++) chk("seq_mode0", obs_log[i], spec_burst[i % NB]);

    // same burst, mode 1
    mode = 3'd1;
    load_burst();
    run_active(4, ACK_ONE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) chk("seq_mode1", obs_log[i], inv_exp[i]);

    // same burst, mode 4: second pass adds frame=1
    mode = 3'd4;
    load_burst();
    run_active(15, ACK_ONE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("seq_mode4_pass2", obs_log[NB + i], frame_exp[i]);

    // consumer stalls 5 cycles while initiator pokes in_stb
    hold_v = out_data;
    run_active(5, ACK_ZERO, 1'b0, 1'b1);
    chk("stall_hold", obs_log[log_n - 1], hold_v);
    run_active(6, ACK_ONE, 1'b0, 1'b0);

    // randomized bursts and traffic
    for (int r = 0; r < 5; r++) begin
      random_burst();
      mode = 3'($urandom_range(0, 7));
      load_burst();
      run_active(60, ACK_RND, 1'b1, 1'b1);
    end

    // abort after 4 bytes; stb high as sync falls
    random_burst();
    mode = 3'd0;
    sync = 1'b1;
    step();
    chk("abort_load_state", dbg_state, S_LOAD);
    for (int i = 0; i < 4; i++) begin
      send_byte(burst[i], acked);
      chk("abort_ack_seen", acked, 1);
      m_cfg[i] = burst[i];
      step();
      chk("abort_ack_pulse", in_ack, 0);
    end
    sync = 1'b0;
    in_stb = 1'b1;
    in_data = 8'h5A;
    step();
    chk("abort_no_ack", in_ack, 0);
    chk("abort_err", cfg_err, 1);
    chk("abort_valid", cfg_valid, 0);
    chk("abort_ostb", out_stb, 0);
    chk("abort_state", dbg_state, S_IDLE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_idle_ack", in_ack, 0);
      chk("abort_idle_ostb", out_stb, 0);
      chk("abort_err_sticky", cfg_err, 1);
    end
    in_stb = 1'b0;

    // reload after abort clears cfg_err
    random_burst();
    mode = 3'd2;
    load_burst();
    run_active(7, ACK_RND, 1'b0, 1'b0);

    // asynchronous reset mid-ACTIVE
    #3;
    rst_pix_n = 1'b0;
    #1;
    chk("arst_in_ack", in_ack, 0);
    chk("arst_out_stb", out_stb, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_valid", cfg_valid, 0);
    chk("arst_err", cfg_err, 0);
    chk("arst_state", dbg_state, S_IDLE);
    step();
    rst_pix_n = 1'b1;
    for (int i = 0; i < NB; i++) m_cfg[i] = 0;
    m_ptr = 0;
    m_frame = 0;
    step();
    chk("post_rst_idle", dbg_state, S_IDLE);
    chk("post_rst_ostb", out_stb, 0);
    random_burst();
    mode = 3'd3;
    load_burst();
    run_active(40, ACK_RND, 1'b1, 1'b0);

`ifdef PPU_CFG_CHECKSUM_EN
    // checksum accepted, then corrupted checksum rejected
    for (int i = 0; i < NB; i++) burst[i] = spec_burst[i];
    mode = 3'd0;
    csum_corrupt = 1'b0;
    load_burst();
    run_active(3, ACK_ONE, 1'b0, 1'b0);
    csum_corrupt = 1'b1;
    load_burst();
    step();
    chk("csum_bad_ostb", out_stb, 0);
    chk("csum_bad_err_hold", cfg_err, 1);
    csum_corrupt = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
